// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the byte-enable memory stage.
package mem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 also decodes as word

  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 4'b0001 << lane;
      SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      default:   return |lane;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] rep_wdata(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] wd);
    case (size)
      SIZE_BYTE: return {4{wd[7:0]}};
      SIZE_HALF: return {2{wd[15:0]}};
      default:   return wd;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                 input logic [1:0]        size,
                                                 input logic [1:0]        lane,
                                                 input logic              sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return {{24{sgn & b[7]}}, b};
      SIZE_HALF: return {{16{sgn & h[15]}}, h};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_be.sv
// Word-organised data RAM with per-byte write enables, async read, sync write.
module dmem_be
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[a][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign rd = mem_q[a];

endmodule

// File: rtl/mem_stage_be.sv
// ME pipeline stage: sized loads/stores, misalignment flag, flush/stall handling.
// Saturating cycle/instruction counters exist only when MEM_PERF_CNT_EN is defined.
module mem_stage_be
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              AnyStall,
  input  logic [31:0]       Result_EX,
  input  logic [31:0]       WrDat_EX,
  input  logic              RegWrite_EX,
  input  logic              MemToReg_EX,
  input  logic              MemWrite_EX,
  input  logic [REG_W-1:0]  WriteReg_EX,
  input  logic [1:0]        Size_EX,
  input  logic              LoadSigned_EX,
  input  logic              InstrVal_EX,
  output logic [31:0]       RdDat_ME,
  output logic [31:0]       Result_ME,
  output logic [REG_W-1:0]  WriteReg_ME,
  output logic              RegWrite_ME,
  output logic              MemToReg_ME,
  output logic [31:0]       ResultRdDat_ME,
  output logic              Misalign_ME,
  output logic [CNT_W-1:0]  Cycles_ME,
  output logic [CNT_W-1:0]  Instr_ME
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              mis, mem_we;
  logic [3:0]        be;
  logic [DATA_W-1:0] wd_rep, ram_rd, ld_ext;

  assign word_idx = Result_EX[ADDR_W+1:2];
  assign lane     = Result_EX[1:0];
  assign mis      = (MemWrite_EX | MemToReg_EX) & is_misaligned(Size_EX, lane);
  assign be       = gen_be(Size_EX, lane);
  assign wd_rep   = rep_wdata(Size_EX, WrDat_EX);
  // Reset gates the write so an edge seen while reset is high cannot corrupt memory.
  assign mem_we   = MemWrite_EX & ~mis & ~AnyStall & ~flush & ~reset;

  dmem_be #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk (clk),
    .we  (mem_we),
    .be  (be),
    .a   (word_idx),
    .wd  (wd_rep),
    .rd  (ram_rd)
  );

  assign ld_ext = load_ext(ram_rd, Size_EX, lane, LoadSigned_EX);

  logic [31:0]      rd_dat_q, rd_dat_d, result_q, result_d;
  logic [REG_W-1:0] write_reg_q, write_reg_d;
  logic             reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
  logic             misalign_q, misalign_d;

  always_comb begin
    rd_dat_d     = rd_dat_q;
    result_d     = result_q;
    write_reg_d  = write_reg_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    misalign_d   = misalign_q;
    if (flush) begin
      rd_dat_d     = '0;
      result_d     = '0;
      write_reg_d  = '0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      misalign_d   = 1'b0;
    end else if (!AnyStall) begin
      rd_dat_d     = ld_ext;
      result_d     = Result_EX;
      write_reg_d  = WriteReg_EX;
      reg_write_d  = RegWrite_EX & ~(mis & MemToReg_EX);
      mem_to_reg_d = MemToReg_EX;
      misalign_d   = mis;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_dat_q     <= '0;
      result_q     <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      rd_dat_q     <= rd_dat_d;
      result_q     <= result_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      misalign_q   <= misalign_d;
    end
  end

  assign RdDat_ME       = rd_dat_q;
  assign Result_ME      = result_q;
  assign WriteReg_ME    = write_reg_q;
  assign RegWrite_ME    = reg_write_q;
  assign MemToReg_ME    = mem_to_reg_q;
  assign Misalign_ME    = misalign_q;
  assign ResultRdDat_ME = mem_to_reg_q ? rd_dat_q : result_q;

`ifdef MEM_PERF_CNT_EN
  logic [CNT_W-1:0] cycles_q, cycles_d, instr_q, instr_d;

  always_comb begin
    cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
    instr_d  = instr_q;
    if (InstrVal_EX && !AnyStall && !flush && !(&instr_q)) instr_d = instr_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
      instr_q  <= '0;
    end else begin
      cycles_q <= cycles_d;
      instr_q  <= instr_d;
    end
  end

  assign Cycles_ME = cycles_q;
  assign Instr_ME  = instr_q;
`else
  logic unused_instr_val;
  assign unused_instr_val = InstrVal_EX;
  assign Cycles_ME        = '0;
  assign Instr_ME         = '0;
`endif

endmodule

// File: tb/tb_mem_stage_be.sv
// Scoreboard bench for mem_stage_be: driver queues expected ME state, monitor compares.
module tb_mem_stage_be;

  localparam int unsigned CNT_W = 4;
`ifdef MEM_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush, AnyStall, RegWrite_EX, MemToReg_EX, MemWrite_EX, LoadSigned_EX;
  logic InstrVal_EX;
  logic [31:0] Result_EX, WrDat_EX;
  logic [4:0]  WriteReg_EX;
  logic [1:0]  Size_EX;
  logic [31:0] RdDat_ME, Result_ME, ResultRdDat_ME;
  logic [4:0]  WriteReg_ME;
  logic        RegWrite_ME, MemToReg_ME, Misalign_ME;
  logic [CNT_W-1:0] Cycles_ME, Instr_ME;

  always #5 clk = ~clk;

  mem_stage_be #(
    .DEPTH (64),
    .REG_W (5),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .AnyStall       (AnyStall),
    .Result_EX      (Result_EX),
    .WrDat_EX       (WrDat_EX),
    .RegWrite_EX    (RegWrite_EX),
    .MemToReg_EX    (MemToReg_EX),
    .MemWrite_EX    (MemWrite_EX),
    .WriteReg_EX    (WriteReg_EX),
    .Size_EX        (Size_EX),
    .LoadSigned_EX  (LoadSigned_EX),
    .InstrVal_EX    (InstrVal_EX),
    .RdDat_ME       (RdDat_ME),
    .Result_ME      (Result_ME),
    .WriteReg_ME    (WriteReg_ME),
    .RegWrite_ME    (RegWrite_ME),
    .MemToReg_ME    (MemToReg_ME),
    .ResultRdDat_ME (ResultRdDat_ME),
    .Misalign_ME    (Misalign_ME),
    .Cycles_ME      (Cycles_ME),
    .Instr_ME       (Instr_ME)
  );

  typedef struct packed {
    logic [31:0] res, wd;
    logic        rw, m2r, mw;
    logic [4:0]  wr;
    logic [1:0]  size;
    logic        sgn, val, stall, flsh;
  } ex_t;

  typedef struct packed {
    logic [31:0]      rd, result;
    logic [4:0]       wr;
    logic             rw, m2r, mis, chk_rd;
    logic [CNT_W-1:0] cyc, ins;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  logic [CNT_W-1:0] cyc_m, ins_m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ex_t st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    ex_t e = '0;
    e.res = a; e.wd = d; e.mw = 1'b1; e.size = sz; e.val = 1'b1;
    return e;
  endfunction

  function automatic ex_t ld(input logic [31:0] a, input logic [1:0] sz, input logic sgn,
                             input logic [4:0] wr);
    ex_t e = '0;
    e.res = a; e.m2r = 1'b1; e.rw = 1'b1; e.size = sz; e.sgn = sgn; e.wr = wr; e.val = 1'b1;
    return e;
  endfunction

  function automatic ex_t alu(input logic [31:0] r, input logic rw, input logic [4:0] wr);
    ex_t e = '0;
    e.res = r; e.rw = rw; e.wr = wr; e.size = 2'b10; e.val = 1'b1;
    return e;
  endfunction

  // Called at posedge+1; applies e, waits one edge, then queues the expected ME state.
  task automatic step(input ex_t e, input logic [31:0] exp_rd, input logic exp_mis);
    exp_t x;
    Result_EX = e.res; WrDat_EX = e.wd; RegWrite_EX = e.rw; MemToReg_EX = e.m2r;
    MemWrite_EX = e.mw; WriteReg_EX = e.wr; Size_EX = e.size; LoadSigned_EX = e.sgn;
    InstrVal_EX = e.val; AnyStall = e.stall; flush = e.flsh;
    @(posedge clk);
    if (e.flsh) begin
      x = '0;
      x.chk_rd = 1'b1;
    end else if (e.stall) begin
      x = last;
    end else begin
      x = '0;
      x.rd = exp_rd; x.result = e.res; x.wr = e.wr; x.m2r = e.m2r; x.mis = exp_mis;
      x.rw = e.rw & ~(exp_mis & e.m2r); x.chk_rd = e.m2r;
    end
    if (cyc_m != '1) cyc_m = cyc_m + 1'b1;
    if (e.val && !e.stall && !e.flsh && ins_m != '1) ins_m = ins_m + 1'b1;
    x.cyc = PerfEn ? cyc_m : '0;
    x.ins = PerfEn ? ins_m : '0;
    last = x;
    exp_q.push_back(x);
    #1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("Result_ME", Result_ME, x.result);
        chk("WriteReg_ME", 32'(WriteReg_ME), 32'(x.wr));
        chk("RegWrite_ME", 32'(RegWrite_ME), 32'(x.rw));
        chk("MemToReg_ME", 32'(MemToReg_ME), 32'(x.m2r));
        chk("Misalign_ME", 32'(Misalign_ME), 32'(x.mis));
        if (x.chk_rd) chk("RdDat_ME", RdDat_ME, x.rd);
        chk("ResultRdDat_ME", ResultRdDat_ME, x.m2r ? x.rd : x.result);
        chk("Cycles_ME", 32'(Cycles_ME), 32'(x.cyc));
        chk("Instr_ME", 32'(Instr_ME), 32'(x.ins));
      end
    end
  end

  initial begin : driver
    ex_t e;
    reset = 1'b1; flush = 1'b0; AnyStall = 1'b0; Result_EX = '0; WrDat_EX = '0;
    RegWrite_EX = 1'b0; MemToReg_EX = 1'b0; MemWrite_EX = 1'b0; WriteReg_EX = '0;
    Size_EX = '0; LoadSigned_EX = 1'b0; InstrVal_EX = 1'b0;
    last = '0; cyc_m = '0; ins_m = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_RegWrite", 32'(RegWrite_ME), 32'd0);
    chk("reset_Result", Result_ME, 32'd0);
    chk("reset_RdDat", RdDat_ME, 32'd0);
    chk("reset_Cycles", 32'(Cycles_ME), 32'd0);

    step(st(32'h4, 32'h11223344, 2'b10), 32'h0, 1'b0);
    step(st(32'h0, 32'h0BADF00D, 2'b10), 32'h0, 1'b0);
    step(st(32'h5, 32'h000000A5, 2'b00), 32'h0, 1'b0);
    step(ld(32'h4, 2'b10, 1'b0, 5'd3), 32'h1122A544, 1'b0);
    step(ld(32'h5, 2'b00, 1'b1, 5'd4), 32'hFFFFFFA5, 1'b0);
    step(ld(32'h5, 2'b00, 1'b0, 5'd5), 32'h000000A5, 1'b0);
    step(ld(32'h6, 2'b01, 1'b1, 5'd6), 32'h00001122, 1'b0);
    step(st(32'h7, 32'h000000C3, 2'b00), 32'h0, 1'b0);
    step(ld(32'h4, 2'b10, 1'b0, 5'd3), 32'hC322A544, 1'b0);
    step(ld(32'h7, 2'b00, 1'b1, 5'd8), 32'hFFFFFFC3, 1'b0);
    // Misaligned half store must not touch word 0.
    step(st(32'h3, 32'h0000BEEF, 2'b01), 32'h0, 1'b1);
    step(ld(32'h0, 2'b10, 1'b0, 5'd2), 32'h0BADF00D, 1'b0);
    step(ld(32'h2, 2'b10, 1'b0, 5'd7), 32'h0BADF00D, 1'b1);
    step(st(32'hE, 32'h00008001, 2'b01), 32'h0, 1'b0);
    step(ld(32'hE, 2'b01, 1'b1, 5'd10), 32'hFFFF8001, 1'b0);
    step(ld(32'hE, 2'b01, 1'b0, 5'd11), 32'h00008001, 1'b0);
    step(alu(32'h12345677, 1'b1, 5'd9), 32'h0, 1'b0);

    // Stalled and flushed stores must not write; ME holds across the stall.
    step(st(32'h8, 32'h01020304, 2'b10), 32'h0, 1'b0);
    e = st(32'h8, 32'hDEADBEEF, 2'b11);
    e.stall = 1'b1;
    repeat (3) step(e, 32'h0, 1'b0);
    e.stall = 1'b0;
    e.flsh  = 1'b1;
    step(e, 32'h0, 1'b0);
    step(ld(32'h8, 2'b10, 1'b0, 5'd12), 32'h01020304, 1'b0);
    step(st(32'h8, 32'hDEADBEEF, 2'b11), 32'h0, 1'b0);
    step(ld(32'h8, 2'b10, 1'b0, 5'd13), 32'hDEADBEEF, 1'b0);

    // Flush overrides stall for a load in EX.
    e = ld(32'h4, 2'b10, 1'b0, 5'd14);
    e.stall = 1'b1;
    e.flsh  = 1'b1;
    step(e, 32'h0, 1'b0);

    for (int i = 0; i < 20; i++) step(alu(32'h100 + i, 1'b0, 5'd0), 32'h0, 1'b0);
    step(alu(32'hCAFE0001, 1'b1, 5'd31), 32'h0, 1'b0);

    // Asynchronous reset between edges clears outputs immediately.
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_RegWrite", 32'(RegWrite_ME), 32'd0);
    chk("midreset_Result", Result_ME, 32'd0);
    chk("midreset_WriteReg", 32'(WriteReg_ME), 32'd0);
    chk("midreset_Cycles", 32'(Cycles_ME), 32'd0);
    chk("midreset_Instr", 32'(Instr_ME), 32'd0);
    Result_EX = 32'h8; WrDat_EX = 32'hFFFFFFFF; MemWrite_EX = 1'b1; Size_EX = 2'b10;
    RegWrite_EX = 1'b0; MemToReg_EX = 1'b0; InstrVal_EX = 1'b1;
    AnyStall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last = '0; cyc_m = '0; ins_m = '0;
    step(ld(32'h8, 2'b10, 1'b0, 5'd15), 32'hDEADBEEF, 1'b0);

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_be.md
Name: mem_stage_be

Overview:
Parametrised successor to the single-word data-memory stage of the 5-stage MIPS pipeline. It sits between EX and writeback and registers all results into the ME stage.
- Adds byte, halfword and word loads/stores with byte enables and sign/zero extension.
- Adds misalignment detection, a synchronous pipeline flush distinct from reset, and saturating performance counters.

Parameters:
DEPTH, 64, data memory depth in 32-bit words; power of two, >= 4.
REG_W, 5, register-file index width.
CNT_W, 16, performance counter width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  synchronous flush; ME stage becomes a bubble next edge
AnyStall  in  1  pipeline stall; ME stage holds, no memory write
Result_EX  in  32  ALU result / byte address
WrDat_EX  in  32  store data, right-justified
RegWrite_EX  in  1  destination write request
MemToReg_EX  in  1  instruction is a load
MemWrite_EX  in  1  instruction is a store
WriteReg_EX  in  REG_W  destination register
Size_EX  in  2  00 byte, 01 half, 10/11 word
LoadSigned_EX  in  1  1 sign-extends, 0 zero-extends byte/half loads
InstrVal_EX  in  1  valid instruction in EX
RdDat_ME  out  32  extended load data
Result_ME  out  32  registered ALU result
WriteReg_ME  out  REG_W  registered destination
RegWrite_ME  out  1  registered, qualified write enable
MemToReg_ME  out  1  registered load flag
ResultRdDat_ME  out  32  MemToReg_ME ? RdDat_ME : Result_ME (combinational)
Misalign_ME  out  1  misaligned load/store retired this cycle
Cycles_ME  out  CNT_W  cycle counter
Instr_ME  out  CNT_W  retired instruction counter

Behaviour:
Reset values:
- All ME registers and counters are 0.
- Memory contents are not reset.

Addressing:
- ADDR_W = clog2(DEPTH).
- Word index = Result_EX[ADDR_W+1:2]. Higher address bits alias (wrap).
- Lane = Result_EX[1:0], little-endian: byte n occupies bits 8n+7:8n.

Misalignment (mis):
- Half access with addr[0]=1 is misaligned.
- Word access with addr[1:0]!=0 is misaligned.
- Only asserted when MemWrite_EX or MemToReg_EX is set.

Stores:
- Byte enables: byte = 1<<lane; half = 0011 or 1100 per addr[1]; word = 1111.
- Write data is replicated across lanes.
- Write occurs at the posedge when MemWrite_EX && !mis && !AnyStall && !flush.

Loads:
- Asynchronous RAM read in EX. Selected lane is extended per LoadSigned_EX and registered, giving a load-to-RdDat_ME latency of 1 cycle.
- A store at edge N is visible to a load in EX during cycle N+1.

ME register update, in priority order:
- flush=1: bubble. RegWrite_ME, MemToReg_ME and Misalign_ME = 0; data and WriteReg = 0. Flush overrides stall.
- AnyStall=1: all ME registers hold.
- Otherwise: capture EX values. Misalign_ME = mis; RegWrite_ME = RegWrite_EX && !(mis && MemToReg_EX).

Counters:
- Cycles_ME increments every cycle.
- Instr_ME increments when InstrVal_EX && !AnyStall && !flush.
- Both saturate at all-ones and are cleared only by reset; flush does not clear them.

Reset asserted mid-operation: outputs clear immediately (asynchronous). Any write on that edge is suppressed.

Optional Feature:
MEM_PERF_CNT_EN
- Defined: counters implemented as above.
- Undefined: no counter flops; Cycles_ME and Instr_ME are tied to 0. All other behaviour is identical.

Decomposition:
- Package mem_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings, DATA_W=32 constant, and functions for byte-enable generation and load extraction/extension.
- Sub-module dmem_be: byte-enable RAM (clk, we, be[3:0], a, wd, rd) with asynchronous read and synchronous write.

Test Plan:
- sw 0x11223344 @0x4; sb 0xA5 @0x5; lw @0x4 -> RdDat_ME=0x1122A544, ResultRdDat_ME same, one cycle after load in EX.
- lb signed @0x5 -> 0xFFFFFFA5; lbu @0x5 -> 0x000000A5; lh signed @0x6 -> 0x00001122.
- sh @0x3 -> Misalign_ME=1 next cycle, word @0x0 unchanged. lw @0x2 with RegWrite_EX=1 -> RegWrite_ME=0, Misalign_ME=1.
- sw 0xDEADBEEF @0x8 with AnyStall=1 for 3 cycles -> no write, ME outputs hold prior values. Release -> write lands and later lw @0x8 returns 0xDEADBEEF. Instr_ME increments once.
- flush and AnyStall both high while a load is in EX -> next cycle RegWrite_ME=0, MemToReg_ME=0, Instr_ME unchanged.
- With CNT_W=4, 20 cycles all valid -> Cycles_ME=Instr_ME=15 (saturated). Assert reset mid-cycle -> both 0 immediately. Macro undefined -> both always 0.
